// File: rtl/idu_pkg.sv
// Shared types and constants for the instruction decode unit: instruction
// classes, opcode encodings, exact-match system words and the decoded bundle.
package idu_pkg;

  // Instruction class carried to the EXU; EXT_INV marks an unknown opcode.
  typedef enum logic [3:0] {
    EXT_JALR   = 4'd0,
    EXT_LOAD   = 4'd1,
    EXT_OPIMM  = 4'd2,
    EXT_FENCE  = 4'd3,
    EXT_SYS    = 4'd4,
    EXT_STORE  = 4'd5,
    EXT_BRANCH = 4'd6,
    EXT_JAL    = 4'd7,
    EXT_LUI    = 4'd8,
    EXT_AUIPC  = 4'd9,
    EXT_R      = 4'd10,
    EXT_INV    = 4'd15
  } ext_e;

  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  // Decoded fields that do not depend on XLEN; the immediate travels beside it.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    ext_e       extop;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       ecall;
    logic       ebreak;
    logic       mret;
    logic       illegal;
  } dec_t;

  function automatic ext_e opcode_class(input logic [6:0] op);
    case (op)
      OP_JALR:   return EXT_JALR;
      OP_LOAD:   return EXT_LOAD;
      OP_OPIMM:  return EXT_OPIMM;
      OP_FENCE:  return EXT_FENCE;
      OP_SYS:    return EXT_SYS;
      OP_STORE:  return EXT_STORE;
      OP_BRANCH: return EXT_BRANCH;
      OP_JAL:    return EXT_JAL;
      OP_LUI:    return EXT_LUI;
      OP_AUIPC:  return EXT_AUIPC;
      OP_R:      return EXT_R;
      default:   return EXT_INV;
    endcase
  endfunction

endpackage

// File: rtl/idu_dec.sv
// Purely combinational RV32I/RV32E decoder: fields, class, sign-extended
// immediate, system flags and the illegal flag for one raw instruction.
module idu_dec
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  localparam logic RV32E = (NREG == 16);

  ext_e        cls;
  logic [31:0] imm32;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        bad_reg;

  // Classify the opcode, build the format-specific immediate and flag illegal encodings.
  always_comb begin
    cls   = opcode_class(instr[6:0]);
    imm32 = '0;
    case (cls)
      EXT_JALR, EXT_LOAD, EXT_OPIMM, EXT_FENCE, EXT_SYS:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      EXT_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      EXT_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      EXT_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      EXT_LUI, EXT_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      default:
        imm32 = '0;
    endcase

    use_rd  = cls inside {EXT_JALR, EXT_LOAD, EXT_OPIMM, EXT_FENCE, EXT_SYS,
                          EXT_JAL, EXT_LUI, EXT_AUIPC, EXT_R};
    use_rs1 = cls inside {EXT_JALR, EXT_LOAD, EXT_OPIMM, EXT_FENCE, EXT_SYS,
                          EXT_STORE, EXT_BRANCH, EXT_R};
    use_rs2 = cls inside {EXT_STORE, EXT_BRANCH, EXT_R};
    bad_reg = (use_rd & instr[11]) | (use_rs1 & instr[19]) | (use_rs2 & instr[24]);

    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.extop   = cls;
    dec.func3   = instr[14:12];
    dec.func7   = instr[31:25];
    dec.ecall   = (instr == INSTR_ECALL);
    dec.ebreak  = (instr == INSTR_EBREAK);
    dec.mret    = (instr == INSTR_MRET);
    dec.illegal = (cls == EXT_INV) | (RV32E & bad_reg);

    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage between IFU and EXU: decodes the input beat and queues the
// result in a DEPTH-entry circular buffer with valid/ready on both sides.
// in_ready is derived only from the registered occupancy so there is no
// combinational path from out_ready back to the IFU.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_extop,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic            out_ecall,
  output logic            out_ebreak,
  output logic            out_mret,
  output logic            out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  dec_t            dec_in;
  logic [XLEN-1:0] imm_in;

  dec_t            dec_mem [DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  dec_t            head;

  idu_dec #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_dec (
    .instr (in_instr),
    .dec   (dec_in),
    .imm   (imm_in)
  );

  // Pointer advance with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Buffer storage, pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dec_mem[i] <= '0;
        imm_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        dec_mem[wr_ptr] <= dec_in;
        imm_mem[wr_ptr] <= imm_in;
        pc_mem[wr_ptr]  <= in_pc;
        wr_ptr          <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = dec_mem[rd_ptr];
  assign out_pc      = pc_mem[rd_ptr];
  assign out_imm     = imm_mem[rd_ptr];
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_extop   = head.extop;
  assign out_func3   = head.func3;
  assign out_func7   = head.func7;
  assign out_ecall   = head.ecall;
  assign out_ebreak  = head.ebreak;
  assign out_mret    = head.mret;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Self-checking bench for idu_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model. A second instance
// with NREG = 16 shares the inputs and is checked against the RV32E rules.
module tb_idu_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int VW    = 97;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_extop;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic        out_ecall, out_ebreak, out_mret, out_illegal;

  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_pc, e_out_imm;
  logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
  logic [3:0]  e_out_extop;
  logic [2:0]  e_out_func3;
  logic [6:0]  e_out_func7;
  logic        e_out_ecall, e_out_ebreak, e_out_mret, e_out_illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;

  logic [6:0] ops [11] = '{7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111,
                           7'b1110011, 7'b0100011, 7'b1100011, 7'b1101111,
                           7'b0110111, 7'b0010111, 7'b0110011};

  idu_pipe #(.XLEN(XLEN), .NREG(32), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_extop(out_extop), .out_func3(out_func3), .out_func7(out_func7),
    .out_ecall(out_ecall), .out_ebreak(out_ebreak), .out_mret(out_mret),
    .out_illegal(out_illegal)
  );

  idu_pipe #(.XLEN(XLEN), .NREG(16), .DEPTH(DEPTH)) u_dut_e (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd), .out_imm(e_out_imm),
    .out_extop(e_out_extop), .out_func3(e_out_func3), .out_func7(e_out_func7),
    .out_ecall(e_out_ecall), .out_ebreak(e_out_ebreak), .out_mret(e_out_mret),
    .out_illegal(e_out_illegal)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference class number straight from the opcode table.
  function automatic int class_of(input logic [31:0] i);
    case (i[6:0])
      7'b1100111: return 0;
      7'b0000011: return 1;
      7'b0010011: return 2;
      7'b0001111: return 3;
      7'b1110011: return 4;
      7'b0100011: return 5;
      7'b1100011: return 6;
      7'b1101111: return 7;
      7'b0110111: return 8;
      7'b0010111: return 9;
      7'b0110011: return 10;
      default:    return 15;
    endcase
  endfunction

  // Reference immediate computed as a signed sum of weighted bit fields.
  function automatic logic [31:0] imm_of(input logic [31:0] i, input int c);
    int v;
    v = 0;
    if (c <= 4) begin
      v = int'(i[30:20]) - (i[31] ? 2048 : 0);
    end else if (c == 5) begin
      v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
    end else if (c == 6) begin
      v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    end else if (c == 7) begin
      v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    end else if (c == 8 || c == 9) begin
      v = int'(i[31:12]) * 4096;
    end
    return 32'(v);
  endfunction

  // Expected output bundle for one queued beat under a given register count.
  function automatic logic [VW-1:0] expect_vec(input beat_t b, input int nreg);
    logic [31:0] i;
    int c;
    bit ec, eb, mr, il, urd, urs1, urs2, bad;
    i    = b.instr;
    c    = class_of(i);
    ec   = (i == 32'h0000_0073);
    eb   = (i == 32'h0010_0073);
    mr   = (i == 32'h3020_0073);
    urd  = (c <= 4) || (c >= 7 && c <= 10);
    urs1 = (c <= 6) || (c == 10);
    urs2 = (c == 5) || (c == 6) || (c == 10);
    bad  = (nreg == 16) && ((urd && i[11:7] >= 16) || (urs1 && i[19:15] >= 16) ||
                            (urs2 && i[24:20] >= 16));
    il   = (c == 15) || bad;
    return {b.pc, i[19:15], i[24:20], i[11:7], imm_of(i, c), 4'(c), i[14:12], i[31:25],
            ec, eb, mr, il};
  endfunction

  function automatic logic [VW-1:0] obs_main();
    return {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_extop, out_func3, out_func7,
            out_ecall, out_ebreak, out_mret, out_illegal};
  endfunction

  function automatic logic [VW-1:0] obs_e();
    return {e_out_pc, e_out_rs1, e_out_rs2, e_out_rd, e_out_imm, e_out_extop, e_out_func3,
            e_out_func7, e_out_ecall, e_out_ebreak, e_out_mret, e_out_illegal};
  endfunction

  // Drive one beat, take the clock edge, advance the model, settle 1 unit later.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit can_push, do_pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    can_push  = v && (q.size() < DEPTH);
    do_pop    = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (can_push) q.push_back(beat_t'{ins, pc});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, in_ready, e_out_valid, e_in_ready} !== 4'b0101) begin
      n_err++;
      $display("[TB] FAIL reset_hs: got %b want 0101", {out_valid, in_ready, e_out_valid, e_in_ready});
    end
    n_vec++;
    if (obs_main() !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_data: got %h want 0", obs_main());
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL post_reset_hs: got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_addi();
    cycle(1'b1, 32'hFFF1_0093, 32'h100, 1'b1, 1'b0);
    n_vec++;
    if ({out_valid, out_extop, out_rd, out_rs1, out_imm, out_illegal} !==
        {1'b1, 4'd2, 5'd1, 5'd2, 32'hFFFF_FFFF, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL addi: got v=%b ext=%0d rd=%0d rs1=%0d imm=%h il=%b want v=1 ext=2 rd=1 rs1=2 imm=ffffffff il=0",
               out_valid, out_extop, out_rd, out_rs1, out_imm, out_illegal);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL addi_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 32'h0010_00EF, 32'h200, 1'b1, 1'b0);
    n_vec++;
    if ({out_valid, in_ready, out_extop, out_rd, out_imm} !== {1'b1, 1'b1, 4'd7, 5'd1, 32'h0000_0800}) begin
      n_err++;
      $display("[TB] FAIL b2b_jal: got v=%b r=%b ext=%0d rd=%0d imm=%h want v=1 r=1 ext=7 rd=1 imm=00000800",
               out_valid, in_ready, out_extop, out_rd, out_imm);
    end
    cycle(1'b1, 32'hFE00_0EE3, 32'h204, 1'b1, 1'b0);
    n_vec++;
    if ({out_valid, in_ready, out_extop, out_pc, out_imm} !== {1'b1, 1'b1, 4'd6, 32'h204, 32'hFFFF_FFFC}) begin
      n_err++;
      $display("[TB] FAIL b2b_beq: got v=%b r=%b ext=%0d pc=%h imm=%h want v=1 r=1 ext=6 pc=204 imm=fffffffc",
               out_valid, in_ready, out_extop, out_pc, out_imm);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_pc[$];
    int          got_cyc[$];
    bit          pend, acc;
    cycle(1'b1, 32'h0010_0193, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0213, 32'h304, 1'b0, 1'b0);
    n_vec++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h300}) begin
      n_err++;
      $display("[TB] FAIL bp_full: got v=%b r=%b pc=%h want v=1 r=0 pc=300", out_valid, in_ready, out_pc);
    end
    cycle(1'b1, 32'h0030_0293, 32'h308, 1'b0, 1'b0);
    n_vec++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h300}) begin
      n_err++;
      $display("[TB] FAIL bp_hold: got v=%b r=%b pc=%h want v=1 r=0 pc=300", out_valid, in_ready, out_pc);
    end
    pend = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        got_pc.push_back(out_pc);
        got_cyc.push_back(k);
      end
      acc = pend && in_ready;
      cycle(pend, 32'h0030_0293, 32'h308, 1'b1, 1'b0);
      if (acc) pend = 1'b0;
    end
    n_vec++;
    if (pend) begin
      n_err++;
      $display("[TB] FAIL bp_accept: got third beat pending=1 want 0");
    end
    n_vec++;
    if (got_pc.size() != 3) begin
      n_err++;
      $display("[TB] FAIL bp_count: got %0d beats want 3", got_pc.size());
    end else begin
      n_vec++;
      if ({got_pc[0], got_pc[1], got_pc[2]} !== {32'h300, 32'h304, 32'h308}) begin
        n_err++;
        $display("[TB] FAIL bp_order: got %h %h %h want 300 304 308", got_pc[0], got_pc[1], got_pc[2]);
      end
      n_vec++;
      if ({got_cyc[0], got_cyc[1], got_cyc[2]} !== {32'd0, 32'd1, 32'd2}) begin
        n_err++;
        $display("[TB] FAIL bp_rate: got cycles %0d %0d %0d want 0 1 2", got_cyc[0], got_cyc[1], got_cyc[2]);
      end
    end
  endtask

  task automatic test_flags();
    logic [31:0] words [4] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h0000_0000};
    logic [3:0]  flags [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0]  exts  [4] = '{4'd4, 4'd4, 4'd4, 4'd15};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, words[k], 32'h400 + 32'(4 * k), 1'b1, 1'b0);
      n_vec++;
      if ({out_valid, out_ecall, out_ebreak, out_mret, out_illegal, out_extop} !==
          {1'b1, flags[k], exts[k]}) begin
        n_err++;
        $display("[TB] FAIL flags_%0d: got v=%b flags=%b ext=%0d want v=1 flags=%b ext=%0d", k,
                 out_valid, {out_ecall, out_ebreak, out_mret, out_illegal}, out_extop, flags[k], exts[k]);
      end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_rv32e();
    cycle(1'b1, 32'h0020_88B3, 32'h500, 1'b1, 1'b0);
    n_vec++;
    if ({e_out_valid, e_out_illegal, e_out_rd, out_illegal} !== {1'b1, 1'b1, 5'd17, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL rv32e_x17: got v=%b il_e=%b rd=%0d il_i=%b want v=1 il_e=1 rd=17 il_i=0",
               e_out_valid, e_out_illegal, e_out_rd, out_illegal);
    end
    cycle(1'b1, 32'h0020_87B3, 32'h504, 1'b1, 1'b0);
    n_vec++;
    if ({e_out_valid, e_out_illegal, e_out_rd, e_out_extop} !== {1'b1, 1'b0, 5'd15, 4'd10}) begin
      n_err++;
      $display("[TB] FAIL rv32e_x15: got v=%b il=%b rd=%0d ext=%0d want v=1 il=0 rd=15 ext=10",
               e_out_valid, e_out_illegal, e_out_rd, e_out_extop);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h0010_0193, 32'h600, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0213, 32'h604, 1'b0, 1'b0);
    n_vec++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL flush_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    cycle(1'b1, 32'h0030_0293, 32'h608, 1'b1, 1'b1);
    n_vec++;
    if ({out_valid, in_ready, e_out_valid, e_in_ready} !== 4'b0101) begin
      n_err++;
      $display("[TB] FAIL flush_clear: got %b want 0101", {out_valid, in_ready, e_out_valid, e_in_ready});
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_absent: got out_valid=%b want 0", out_valid);
    end
    cycle(1'b1, 32'h0040_0313, 32'h60C, 1'b1, 1'b0);
    n_vec++;
    if ({out_valid, out_pc} !== {1'b1, 32'h60C}) begin
      n_err++;
      $display("[TB] FAIL flush_restart: got v=%b pc=%h want v=1 pc=60c", out_valid, out_pc);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r, ins;
    int sel;
    for (int k = 0; k < 400; k++) begin
      n_vec++;
      if ({out_valid, in_ready, e_out_valid, e_in_ready} !==
          {q.size() != 0, q.size() < DEPTH, q.size() != 0, q.size() < DEPTH}) begin
        n_err++;
        $display("[TB] FAIL rand_hs @%0d: got %b want depth %0d", k,
                 {out_valid, in_ready, e_out_valid, e_in_ready}, q.size());
      end
      if (q.size() != 0) begin
        n_vec++;
        if (obs_main() !== expect_vec(q[0], 32)) begin
          n_err++;
          $display("[TB] FAIL rand_i @%0d instr=%h: got %h want %h", k, q[0].instr, obs_main(), expect_vec(q[0], 32));
        end
        n_vec++;
        if (obs_e() !== expect_vec(q[0], 16)) begin
          n_err++;
          $display("[TB] FAIL rand_e @%0d instr=%h: got %h want %h", k, q[0].instr, obs_e(), expect_vec(q[0], 16));
        end
      end
      r   = $urandom();
      sel = $urandom_range(0, 39);
      if (sel < 3)       ins = r;
      else if (sel == 3) ins = 32'h0000_0073;
      else if (sel == 4) ins = 32'h0010_0073;
      else if (sel == 5) ins = 32'h3020_0073;
      else               ins = {r[31:7], ops[$urandom_range(0, 10)]};
      cycle($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    end
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h0010_0193, 32'h700, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0213, 32'h704, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_pc, out_extop} !== {1'b0, 1'b1, 32'h0, 4'd0}) begin
      n_err++;
      $display("[TB] FAIL async_reset: got v=%b r=%b pc=%h ext=%0d want v=0 r=1 pc=0 ext=0",
               out_valid, in_ready, out_pc, out_extop);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_rv32e();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
# idu_pipe

Pipelined, parametrised instruction decode unit for the NPC core. It sits between the IFU and the EXU and decodes RV32I/RV32E instructions: register indices, sign-extended immediate, extop class, func3/func7, system-instruction flags and an illegal flag. It adds valid/ready handshakes on both sides, a small output buffer so decode never throttles back-to-back fetch, and a flush input for redirects and traps.

## Interface
Parameters:
- XLEN, 32: instruction, PC and immediate width (≥ 32; immediates sign-extend to XLEN).
- NREG, 32: architectural register count, 32 or 16. 16 selects RV32E, so any used rs1/rs2/rd with bit 4 set is illegal.
- DEPTH, 2: output buffer entries (≥ 1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries and the current input beat.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  entry free (count < DEPTH), registered-count based.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle at head is valid.
- out_ready  in  1  EXU accepts the head.
- out_pc  out  XLEN  PC of the head.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  immediate selected by extop.
- out_extop  out  4  instruction class.
- out_func3  out  3; out_func7  out  7.
- out_ecall, out_ebreak, out_mret, out_illegal  out  1 each.

## Operation
- Opcodes map to out_extop as follows:
  - 1100111 → 0 (jalr), 0000011 → 1 (load), 0010011 → 2 (op-imm), 0001111 → 3 (fence), 1110011 → 4 (system).
  - 0100011 → 5 (store), 1100011 → 6 (branch), 1101111 → 7 (jal), 0110111 → 8 (lui), 0010111 → 9 (auipc), 0110011 → 10 (R-type).
  - Any other opcode → 15, with illegal = 1.
- Immediate by format:
  - I: extop 0–4, instr[31:20].
  - S: extop 5.
  - B: extop 6, {31,7,30:25,11:8,0}.
  - J: extop 7, {31,19:12,20,30:21,0}.
  - U: extop 8–9, {31:12, 12'b0}.
  - extop 10 and 15 give imm = 0.
  - All immediates sign-extend from bit 31.
- Flags: ecall = (instr == 0x00000073), ebreak = (instr == 0x00100073), mret = (instr == 0x30200073). Other system encodings decode normally as extop 4 (csr).
- RV32E (NREG = 16) sets illegal if any field used by the class has bit 4 set:
  - rd: extop 0–4 and 7–10.
  - rs1: extop 0–6 and 10.
  - rs2: extop 5, 6, 10.
- Decode is combinational on the input beat. The result is written into a circular FIFO of DEPTH entries on push (in_valid & in_ready & !flush). Pop occurs on out_valid & out_ready.
- Count update:
  - Push and pop in the same cycle: count unchanged, pointers both advance (wrap modulo DEPTH).
  - Full: in_ready = 0, no push.
  - Empty: out_valid = 0; outputs hold the last head contents (don't-care for checking).
- flush has priority: next cycle count = 0, pointers reset, and any same-cycle push and pop are ignored.
- The ebreak DPI call moves out of decode to commit; this block calls no DPI.

## Timing
- Latency: an instruction accepted in cycle N appears at out_* with out_valid = 1 in cycle N+1 at the earliest.
- Throughput: 1 instruction/cycle sustained while out_ready = 1.
- in_ready depends only on registered count; no combinational path from out_ready to in_ready.
- Once asserted, out_valid and the head bundle stay stable until popped or flushed.
- Reset state: count = 0, pointers = 0, out_valid = 0, in_ready = 1, all bundle storage and data outputs = 0, out_extop = 0.
- Reset asserted mid-stream drops all entries immediately (asynchronous).

## Structure
- Package idu_pkg holds:
  - The extop enum: EXT_JALR … EXT_R, EXT_INV = 15.
  - Opcode constants.
  - The three system-instruction constants.
  - A packed struct dec_t for the decoded bundle.
- Sub-module idu_dec: purely combinational decode from instr to dec_t, parametrised by XLEN and NREG.
- idu_pipe wraps idu_dec plus the DEPTH-entry dec_t FIFO and its handshake logic.

## Test plan
- Reset, then feed addi x1,x2,-1 (0xFFF10093) with out_ready = 1. Next cycle: extop 2, rd 1, rs1 2, imm 0xFFFFFFFF, illegal 0.
- Back-to-back jal x1,+2048 (0x001000EF), then beq x0,x0,-4 (0xFE000EE3). Expect two consecutive out beats: imm 0x00000800, then 0xFFFFFFFC; in_ready stays 1.
- Hold out_ready = 0 and push 3 instructions. in_ready drops after 2 accepted and the third is held at the input. Release: all three emerge in order, one per cycle.
- ecall, ebreak, mret and 0x00000000 each give exactly one flag. 0x00000000 gives illegal = 1 and extop 15.
- NREG = 16: add x17,x1,x2 (0x002088B3) gives illegal = 1. add x15,x1,x2 gives illegal = 0.
- Buffer full with push and pop in the same cycle as flush. Next cycle: out_valid = 0, in_ready = 1, and the pushed instruction is absent.
